uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Controller that shares one UART transmitter between NREQ byte requesters using round-robin arbitration.
- Sequences the transmitter through its wr_en/tx_busy handshake.
- Drains the UART receiver through its rdy/rdy_clr handshake into a valid/ready byte stream.
- Sits between the uart top (din, wr_en, tx_busy, rdy, rdy_clr, dout) and on-chip clients.

Parameters:
NREQ, 4, number of transmit requesters (2..8)
IDW, 2, grant index width; must equal ceil(log2(NREQ)), minimum 1

Ports:
clk_50m  input  1  system clock
rst  input  1  asynchronous reset, active-high
req_valid  input  NREQ  per-requester byte valid
req_data  input  NREQ*8  per-requester byte; requester i occupies bits [8i+7:8i]
req_ready  output  NREQ  per-requester accept, one-hot or zero
grant_id  output  IDW  index of the requester being serviced
tx_active  output  1  high while a byte is in flight to or through the transmitter
uart_din  output  8  byte to transmitter
uart_wr_en  output  1  transmitter write enable
uart_tx_busy  input  1  transmitter busy
uart_rdy  input  1  receiver byte ready
uart_rdy_clr  output  1  receiver ready clear
uart_dout  input  8  receiver byte
rx_valid  output  1  received byte available
rx_data  output  8  received byte
rx_ready  input  1  consumer accepts rx byte

Behaviour:
Interface:
- One clock, clk_50m. Reset rst is asynchronous and active-high.
- All state is registered on clk_50m rising edge; rst clears it immediately.

Reset values:
- req_ready=0, grant_id=0, tx_active=0, uart_din=0, uart_wr_en=0, uart_rdy_clr=0, rx_valid=0, rx_data=0.
- Round-robin pointer=0, so requester 0 has highest priority first.

TX FSM states: IDLE, LOAD, WAIT_DONE.
- IDLE:
  - req_ready is combinational. It asserts one-hot for the winner among req_valid, searching from the pointer upward with wrap-around.
  - Handshake completes when req_valid[i]&req_ready[i] at a clock edge. At that edge: capture req_data[i] into uart_din, set grant_id=i, pointer=(i+1) mod NREQ, go to LOAD.
  - No valid -> req_ready=0, stay in IDLE.
- LOAD:
  - uart_wr_en=1 and tx_active=1.
  - Stay until uart_tx_busy=1 is sampled. On that edge: deassert uart_wr_en and go to WAIT_DONE.
  - uart_wr_en is therefore a level held until busy is seen (minimum 1 cycle), never a blind pulse.
- WAIT_DONE:
  - uart_wr_en=0, tx_active=1.
  - On uart_tx_busy=0: go to IDLE with tx_active=0.
- Back-to-back: a new grant is possible in the first IDLE cycle after WAIT_DONE.
  - Minimum request spacing is the transmitter frame time plus 2 cycles.
- req_ready is 0 in every state except IDLE.
- A requester dropping req_valid before the handshake loses nothing; re-arbitration happens every IDLE cycle.
- uart_din is held stable from LOAD through WAIT_DONE.
- Fairness: with all NREQ valid continuously, grants go 0,1,2,3,0,... For NREQ=4 no requester waits more than 3 grants.
- uart_tx_busy already high in IDLE (transmitter still active after reset): arbitration proceeds. LOAD then sees busy immediately and WAIT_DONE waits for it to fall; the byte is still accepted.

RX path: holding register with state EMPTY/FULL; rx_valid = FULL.
- EMPTY and uart_rdy=1:
  - Capture uart_dout into rx_data.
  - Set rx_valid=1.
  - Assert uart_rdy_clr for exactly one cycle (the following cycle).
- FULL and rx_valid&rx_ready: go to EMPTY.
  - If uart_rdy is also 1 in that cycle, the new byte is not captured until the next cycle. uart_rdy_clr has not been issued for it, so it is not lost.
- FULL and uart_rdy=1: no capture and no rdy_clr. Backpressure leaves the byte in the receiver.
- uart_rdy_clr never asserts on two consecutive cycles. After a clear, uart_rdy is ignored for one cycle so a stale rdy cannot cause a double capture.
- TX and RX paths are independent. Simultaneous activity on both is legal.

Reset mid-operation:
- All outputs return to reset values asynchronously, including uart_wr_en=0 and uart_rdy_clr=0.
- Any in-flight byte is abandoned. The transmitter completes its frame and sees no new wr_en.

Decomposition:
- Shared package uart_pkg: TX state encoding (IDLE=2'd0, LOAD=2'd1, WAIT_DONE=2'd2) and the byte-width constant 8.
- One sub-module, rr_arbiter:
  - Inputs: req vector and pointer. Output: one-hot grant plus encoded index.
  - Purely combinational.
  - Reusable by the team's future bus arbiters.

Test Plan:
- Reset then req_valid=4'b0001, req_data[7:0]=8'hA5 -> req_ready[0]=1 same cycle. Next cycle uart_wr_en=1 and uart_din=8'hA5. Deasserts the cycle after the transmitter model raises uart_tx_busy. tx_active falls when busy falls.
- req_valid=4'b1111 held, bytes 8'h10/8'h21/8'h32/8'h43 -> grant_id sequence 0,1,2,3,0. Serial output carries 10,21,32,43,10.
- Pointer=2 and req_valid=4'b0011 -> requester 0 granted (wrap-around search). The next grant goes to requester 1.
- Receiver presents uart_rdy=1 with dout=8'h5C, rx_ready=0 -> rx_valid=1, rx_data=8'h5C, one uart_rdy_clr pulse. A second rdy with 8'h7E yields no clear until rx_ready=1. Then 8'h7E is captured.
- Assert rst while in LOAD with uart_wr_en=1 -> uart_wr_en, req_ready and tx_active go to 0 without waiting for a clock. After release, the pointer is 0 and the next request is serviced normally.
- Simultaneous TX grant and RX capture on the same cycle -> both complete with no lost byte and correct data on both sides.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared TX state encoding and byte width for the uart arbiter slice
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - client and uart-side signals of the shared transmitter controller
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  import uart_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*BYTE_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic [IDW-1:0]         grant_id;
  logic                   tx_active;
  logic [BYTE_W-1:0]      uart_din;
  logic                   uart_wr_en;
  logic                   uart_tx_busy;
  logic                   uart_rdy;
  logic                   uart_rdy_clr;
  logic [BYTE_W-1:0]      uart_dout;
  logic                   rx_valid;
  logic [BYTE_W-1:0]      rx_data;
  logic                   rx_ready;

  modport master (
    input  req_valid, req_data, uart_tx_busy, uart_rdy, uart_dout, rx_ready,
    output req_ready, grant_id, tx_active, uart_din, uart_wr_en, uart_rdy_clr,
           rx_valid, rx_data
  );

  modport slave (
    output req_valid, req_data, uart_tx_busy, uart_rdy, uart_dout, rx_ready,
    input  req_ready, grant_id, tx_active, uart_din, uart_wr_en, uart_rdy_clr,
           rx_valid, rx_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first request at or above ptr, wrapping
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Winner is the requester with the smallest wrap-around distance from ptr.
  always_comb begin
    int best_d;
    int best_i;
    int d;
    best_d = N;
    best_i = 0;
    d      = 0;
    grant  = '0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - int'(ptr)) % N;
      if (req[i] && d < best_d) begin
        best_d = d;
        best_i = i;
      end
    end
    any = (best_d < N);
    for (int i = 0; i < N; i++) begin
      grant[i] = any && (i == best_i);
    end
    idx = IDW'(best_i);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart transmitter plus receiver drain to a byte stream
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk_50m,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);

  tx_state_e         state_q, state_d;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    gid_q;
  logic [BYTE_W-1:0] din_q;
  logic [NREQ-1:0]   win_grant;
  logic [IDW-1:0]    win_idx;
  logic              win_any;
  logic [BYTE_W-1:0] sel_byte;
  logic              accept;

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_grant[i]) sel_byte = bus.req_data[i*BYTE_W +: BYTE_W];
    end
  end

  assign accept = (state_q == IDLE) && win_any;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (win_any) state_d = LOAD;
      LOAD:      if (bus.uart_tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!bus.uart_tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        din_q <= sel_byte;
        gid_q <= win_idx;
        ptr_q <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  // req_ready is combinational, so it is also gated by rst to drop without a clock.
  assign bus.req_ready  = (state_q == IDLE && !rst) ? win_grant : '0;
  assign bus.grant_id   = gid_q;
  assign bus.uart_din   = din_q;
  assign bus.uart_wr_en = (state_q == LOAD);
  assign bus.tx_active  = (state_q != IDLE);

  logic              rx_full_q;
  logic              clr_q;
  logic              hold_q;
  logic [BYTE_W-1:0] rx_data_q;
  logic              capture;

  // hold_q masks the cycle after a clear, when the receiver's rdy may still be stale.
  assign capture = !rx_full_q && bus.uart_rdy && !clr_q && !hold_q;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rx_full_q <= 1'b0;
      clr_q     <= 1'b0;
      hold_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      clr_q  <= capture;
      hold_q <= clr_q;
      if (capture) begin
        rx_full_q <= 1'b1;
        rx_data_q <= bus.uart_dout;
      end else if (rx_full_q && bus.rx_ready) begin
        rx_full_q <= 1'b0;
      end
    end
  end

  assign bus.rx_valid     = rx_full_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.uart_rdy_clr = clr_q;

endmodule
